// File: rtl/vc_input_buffer.sv
// vc_input_buffer: per-input-port virtual-channel buffer upstream of the switch.
// One FIFO per VC, round-robin head selection with a hold lock while the switch
// stalls, per-VC free-space flags and one credit pulse per dequeued flit.
// Optional feature: define VC_BUFFER_ERR_EN to add the sticky err_overflow port.

package vc_input_buffer_pkg;
    localparam int FLIT_W = 32;
    typedef logic [FLIT_W-1:0] flit_t;
endpackage

module vc_input_buffer
    import vc_input_buffer_pkg::*;
#(
    parameter  int NUM_VCS = 2,
    parameter  int DEPTH   = 4,
    localparam int VC_W    = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  flit_t              in_flit,
    input  logic [VC_W-1:0]    in_vc,
    output flit_t              out_flit,
    output logic [VC_W-1:0]    out_vc,
    output logic               data_ready,
    input  logic               pop,
    output logic [NUM_VCS-1:0] buffer_available,
    output logic [NUM_VCS-1:0] credit_return
`ifdef VC_BUFFER_ERR_EN
    ,
    output logic               err_overflow
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [VC_W-1:0]  vc_t;

    localparam ptr_t PTR_LAST = PTR_W'(DEPTH - 1);
    localparam cnt_t CNT_FULL = CNT_W'(DEPTH);

    // Per-VC storage and bookkeeping
    flit_t r_mem    [NUM_VCS][DEPTH];
    ptr_t  r_rd_ptr [NUM_VCS];
    ptr_t  r_wr_ptr [NUM_VCS];
    cnt_t  r_count  [NUM_VCS];

    // Arbitration state
    vc_t                r_rr_ptr;
    vc_t                r_lock_vc;
    logic               r_locked;
    logic [NUM_VCS-1:0] r_credit;

    // Combinational decode
    logic [NUM_VCS-1:0] w_has_data;
    logic [NUM_VCS-1:0] w_push_vec;
    logic [NUM_VCS-1:0] w_pop_vec;
    vc_t                w_rr_sel;
    logic               w_rr_hit;
    vc_t                w_sel;
    logic               w_data_ready;
    logic               w_in_vc_ok;
    logic               w_push_ok;
    logic               w_pop_ok;

    // Pointer increment with wrap at DEPTH-1 (DEPTH need not be a power of 2)
    function automatic ptr_t ptr_next(input ptr_t p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // VC index `offset` positions after `base`, modulo NUM_VCS
    function automatic vc_t rr_index(input vc_t base, input int offset);
        return vc_t'((int'(base) + offset) % NUM_VCS);
    endfunction

    // Per-VC occupancy flags and free-space report
    always_comb begin
        for (int v = 0; v < NUM_VCS; v++) begin
            w_has_data[v]       = (r_count[v] != '0);
            buffer_available[v] = (r_count[v] != CNT_FULL);
        end
    end

    // Round-robin search for the first non-empty VC after the last served one
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_rr_sel = '0;
        w_rr_hit = 1'b0;
        for (int i = 1; i <= NUM_VCS; i++) begin
            if (!w_rr_hit && w_has_data[rr_index(r_rr_ptr, i)]) begin
                w_rr_sel = rr_index(r_rr_ptr, i);
                w_rr_hit = 1'b1;
            end
        end
    end

    // Head presentation: a stalled head stays locked until the switch pops it
    always_comb begin
        w_sel        = r_locked ? r_lock_vc : w_rr_sel;
        w_data_ready = w_has_data[w_sel];
        out_flit     = r_mem[w_sel][r_rd_ptr[w_sel]];
        out_vc       = w_sel;
        data_ready   = w_data_ready;
    end

    // Accept/dequeue qualification and per-VC one-hot strobes
    always_comb begin
        w_in_vc_ok = ({1'b0, in_vc} < (VC_W + 1)'(NUM_VCS));
        w_push_ok  = in_valid && w_in_vc_ok && (r_count[in_vc] != CNT_FULL);
        w_pop_ok   = pop && w_data_ready;
        for (int v = 0; v < NUM_VCS; v++) begin
            w_push_vec[v] = w_push_ok && (in_vc == vc_t'(v));
            w_pop_vec[v]  = w_pop_ok && (w_sel == vc_t'(v));
        end
    end

    // Flit storage write; the full check above makes a push to a full VC a drop
    // NOTE: storage is not reset; count gates every read, so stale entries are never presented.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[in_vc][r_wr_ptr[in_vc]] <= in_flit;
        end
    end

    // Per-VC pointers and occupancy; reset discards all stored flits at once
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                r_rd_ptr[v] <= '0;
                r_wr_ptr[v] <= '0;
                r_count[v]  <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VCS; v++) begin
                if (w_push_vec[v]) begin
                    r_wr_ptr[v] <= ptr_next(r_wr_ptr[v]);
                end
                if (w_pop_vec[v]) begin
                    r_rd_ptr[v] <= ptr_next(r_rd_ptr[v]);
                end
                if (w_push_vec[v] && !w_pop_vec[v]) begin
                    r_count[v] <= r_count[v] + CNT_W'(1);
                end else if (!w_push_vec[v] && w_pop_vec[v]) begin
                    r_count[v] <= r_count[v] - CNT_W'(1);
                end
            end
        end
    end

    // Round-robin pointer, head lock and credit pulse generation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr  <= vc_t'(NUM_VCS - 1);
            r_locked  <= 1'b0;
            r_lock_vc <= '0;
            r_credit  <= '0;
        end else begin
            r_credit <= w_pop_vec;
            if (w_pop_ok) begin
                r_rr_ptr <= w_sel;
                r_locked <= 1'b0;
            end else if (w_data_ready) begin
                r_locked  <= 1'b1;
                r_lock_vc <= w_sel;
            end
        end
    end

    assign credit_return = r_credit;

`ifdef VC_BUFFER_ERR_EN
    logic r_err;

    // Sticky flag for any push that had to be dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (in_valid && !w_push_ok) begin
            r_err <= 1'b1;
        end
    end

    assign err_overflow = r_err;
`endif

endmodule

// File: tb/tb_vc_input_buffer.sv
// Directed, table-driven bench for vc_input_buffer (NUM_VCS=2, DEPTH=4).
// Each table row drives one cycle's inputs at the falling edge and checks the
// outputs visible in that cycle before the next rising edge.

module tb_vc_input_buffer;
    import vc_input_buffer_pkg::*;

    localparam int NUM_VCS = 2;
    localparam int DEPTH   = 4;
    localparam int VC_W    = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;

    logic               clk;
    logic               rst;
    logic               in_valid;
    flit_t              in_flit;
    logic [VC_W-1:0]    in_vc;
    flit_t              out_flit;
    logic [VC_W-1:0]    out_vc;
    logic               data_ready;
    logic               pop;
    logic [NUM_VCS-1:0] buffer_available;
    logic [NUM_VCS-1:0] credit_return;
`ifdef VC_BUFFER_ERR_EN
    logic               err_overflow;
`endif

    vc_input_buffer #(.NUM_VCS(NUM_VCS), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_flit          (in_flit),
        .in_vc            (in_vc),
        .out_flit         (out_flit),
        .out_vc           (out_vc),
        .data_ready       (data_ready),
        .pop              (pop),
        .buffer_available (buffer_available),
        .credit_return    (credit_return)
`ifdef VC_BUFFER_ERR_EN
        ,
        .err_overflow     (err_overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic               rst;
        logic               in_valid;
        logic [VC_W-1:0]    in_vc;
        flit_t              in_flit;
        logic               pop;
        logic               e_dr;
        logic [VC_W-1:0]    e_vc;
        flit_t              e_flit;
        logic [NUM_VCS-1:0] e_avail;
        logic [NUM_VCS-1:0] e_credit;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input int r, input int iv, input int ivc, input int fl,
                                input int p, input int dr, input int ovc, input int ofl,
                                input int av, input int cr);
        vec_t v;
        v.rst      = r[0];
        v.in_valid = iv[0];
        v.in_vc    = VC_W'(ivc);
        v.in_flit  = flit_t'(fl);
        v.pop      = p[0];
        v.e_dr     = dr[0];
        v.e_vc     = VC_W'(ovc);
        v.e_flit   = flit_t'(ofl);
        v.e_avail  = NUM_VCS'(av);
        v.e_credit = NUM_VCS'(cr);
        vecs.push_back(v);
    endfunction

    // One cycle: drive inputs after the falling edge, settle, then caller checks
    task automatic cyc(input logic iv, input int ivc, input int fl, input logic p);
        @(negedge clk);
        in_valid = iv;
        in_vc    = VC_W'(ivc);
        in_flit  = flit_t'(fl);
        pop      = p;
        #1;
    endtask

    initial begin
        //   rst iv vc flit   pop | dr vc flit   avail cr
        // Idle after reset, then A,B to VC0 with pop as soon as the head is valid
        add(0, 0, 0, 'h0,  0,  0, 0, 'h0,  3, 0);
        add(0, 1, 0, 'hA,  0,  0, 0, 'h0,  3, 0);
        add(0, 1, 0, 'hB,  1,  1, 0, 'hA,  3, 0);
        add(0, 0, 0, 'h0,  1,  1, 0, 'hB,  3, 1);
        add(0, 0, 0, 'h0,  0,  0, 0, 'h0,  3, 1);
        add(0, 0, 0, 'h0,  0,  0, 0, 'h0,  3, 0);
        // Fill VC1 to DEPTH, 5th push dropped, then drain in order
        add(0, 1, 1, 'h11, 0,  0, 0, 'h0,  3, 0);
        add(0, 1, 1, 'h12, 0,  1, 1, 'h11, 3, 0);
        add(0, 1, 1, 'h13, 0,  1, 1, 'h11, 3, 0);
        add(0, 1, 1, 'h14, 0,  1, 1, 'h11, 3, 0);
        add(0, 1, 1, 'h15, 0,  1, 1, 'h11, 1, 0);
        add(0, 0, 0, 'h0,  1,  1, 1, 'h11, 1, 0);
        add(0, 0, 0, 'h0,  1,  1, 1, 'h12, 3, 2);
        add(0, 0, 0, 'h0,  1,  1, 1, 'h13, 3, 2);
        add(0, 0, 0, 'h0,  1,  1, 1, 'h14, 3, 2);
        add(0, 0, 0, 'h0,  0,  0, 0, 'h0,  3, 2);
        add(0, 0, 0, 'h0,  0,  0, 0, 'h0,  3, 0);
        // Preload VC0={A,C}, VC1={B,D}; round-robin gives A,B,C,D
        add(0, 1, 0, 'hA,  0,  0, 0, 'h0,  3, 0);
        add(0, 1, 1, 'hB,  0,  1, 0, 'hA,  3, 0);
        add(0, 1, 0, 'hC,  0,  1, 0, 'hA,  3, 0);
        add(0, 1, 1, 'hD,  0,  1, 0, 'hA,  3, 0);
        add(0, 0, 0, 'h0,  1,  1, 0, 'hA,  3, 0);
        add(0, 0, 0, 'h0,  1,  1, 1, 'hB,  3, 1);
        add(0, 0, 0, 'h0,  1,  1, 0, 'hC,  3, 2);
        add(0, 0, 0, 'h0,  1,  1, 1, 'hD,  3, 1);
        add(0, 0, 0, 'h0,  0,  0, 0, 'h0,  3, 2);
        add(0, 0, 0, 'h0,  0,  0, 0, 'h0,  3, 0);
        // Serve VC0 once so round-robin favours VC1, then stall head A on VC0
        // while VC1 fills: the lock must keep A presented
        add(0, 1, 0, 'h30, 0,  0, 0, 'h0,  3, 0);
        add(0, 1, 0, 'hA,  1,  1, 0, 'h30, 3, 0);
        add(0, 1, 1, 'h21, 0,  1, 0, 'hA,  3, 1);
        add(0, 1, 1, 'h22, 0,  1, 0, 'hA,  3, 0);
        add(0, 1, 1, 'h23, 0,  1, 0, 'hA,  3, 0);
        add(0, 0, 0, 'h0,  1,  1, 0, 'hA,  3, 0);
        add(0, 0, 0, 'h0,  1,  1, 1, 'h21, 3, 1);
        add(0, 0, 0, 'h0,  1,  1, 1, 'h22, 3, 2);
        add(0, 0, 0, 'h0,  1,  1, 1, 'h23, 3, 2);
        add(0, 0, 0, 'h0,  0,  0, 0, 'h0,  3, 2);
        // Fill VC0 with 3 flits, reset mid-stream (pop in the reset cycle is lost)
        add(0, 1, 0, 'h41, 0,  0, 0, 'h0,  3, 0);
        add(0, 1, 0, 'h42, 0,  1, 0, 'h41, 3, 0);
        add(0, 1, 0, 'h43, 0,  1, 0, 'h41, 3, 0);
        add(1, 0, 0, 'h0,  1,  0, 0, 'h0,  3, 0);
        add(0, 0, 0, 'h0,  0,  0, 0, 'h0,  3, 0);
        add(0, 1, 1, 'h50, 0,  0, 0, 'h0,  3, 0);
        add(0, 0, 0, 'h0,  1,  1, 1, 'h50, 3, 0);
        add(0, 0, 0, 'h0,  0,  0, 0, 'h0,  3, 2);

        rst      = 1'b1;
        in_valid = 1'b0;
        in_vc    = '0;
        in_flit  = '0;
        pop      = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
`ifdef VC_BUFFER_ERR_EN
        check("reset err_overflow", 32'(err_overflow), 32'h0);
`endif

        foreach (vecs[i]) begin
            @(negedge clk);
            rst      = vecs[i].rst;
            in_valid = vecs[i].in_valid;
            in_vc    = vecs[i].in_vc;
            in_flit  = vecs[i].in_flit;
            pop      = vecs[i].pop;
            #1;
            check($sformatf("row%0d data_ready", i), 32'(data_ready), 32'(vecs[i].e_dr));
            check($sformatf("row%0d out_vc", i), 32'(out_vc), 32'(vecs[i].e_vc));
            check($sformatf("row%0d buffer_available", i), 32'(buffer_available), 32'(vecs[i].e_avail));
            check($sformatf("row%0d credit_return", i), 32'(credit_return), 32'(vecs[i].e_credit));
            if (vecs[i].e_dr) begin
                check($sformatf("row%0d out_flit", i), out_flit, vecs[i].e_flit);
            end
        end

        // Push into a full VC in the same cycle it is popped: the push is dropped
        cyc(1'b1, 0, 'h60, 1'b0);
        cyc(1'b1, 0, 'h61, 1'b0);
        cyc(1'b1, 0, 'h62, 1'b0);
        cyc(1'b1, 0, 'h63, 1'b0);
        cyc(1'b1, 0, 'h64, 1'b1);
        check("full avail", 32'(buffer_available), 32'h2);
        check("full head", out_flit, 32'h60);
`ifdef VC_BUFFER_ERR_EN
        check("err before drop", 32'(err_overflow), 32'h0);
`endif
        cyc(1'b0, 0, 0, 1'b1);
        check("drop avail", 32'(buffer_available), 32'h3);
        check("drop credit", 32'(credit_return), 32'h1);
        check("drop head61", out_flit, 32'h61);
`ifdef VC_BUFFER_ERR_EN
        check("err after drop", 32'(err_overflow), 32'h1);
`endif
        cyc(1'b0, 0, 0, 1'b1);
        check("drop head62", out_flit, 32'h62);
        cyc(1'b0, 0, 0, 1'b1);
        check("drop head63", out_flit, 32'h63);
        check("drop dr63", 32'(data_ready), 32'h1);
        cyc(1'b0, 0, 0, 1'b0);
        check("drop empty", 32'(data_ready), 32'h0);
        check("drop last credit", 32'(credit_return), 32'h1);

        // No same-cycle bypass; credit is a single-cycle pulse; pop on empty is ignored
        cyc(1'b1, 1, 'h70, 1'b0);
        check("bypass dr", 32'(data_ready), 32'h0);
        check("bypass credit", 32'(credit_return), 32'h0);
        cyc(1'b0, 0, 0, 1'b0);
        check("latency dr", 32'(data_ready), 32'h1);
        check("latency flit", out_flit, 32'h70);
        check("latency vc", 32'(out_vc), 32'h1);
        cyc(1'b0, 0, 0, 1'b1);
        cyc(1'b0, 0, 0, 1'b1);
        check("empty pop dr", 32'(data_ready), 32'h0);
        check("pulse credit", 32'(credit_return), 32'h2);
        cyc(1'b0, 0, 0, 1'b0);
        check("ignored pop credit", 32'(credit_return), 32'h0);
        check("ignored pop avail", 32'(buffer_available), 32'h3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
